// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg
//   Shared constants and helpers for the round-robin N:1 selector.
//   MAX_CH  : largest channel count the selector is meant to be built with.
//   rr_next : successor of the granted channel, wrapping at num_ch so that
//             non-power-of-2 channel counts rotate correctly.
package rr_mux_pkg;

  localparam int MAX_CH = 16;

  // An out-of-range grant never moves the pointer, so it is returned
  // unchanged; otherwise the pointer lands just past the winner.
  function automatic int rr_next(input int ptr, input int g, input int num_ch);
    if (g < 0 || g >= num_ch) begin
      return ptr;
    end else if (g == num_ch - 1) begin
      return 0;
    end else begin
      return g + 1;
    end
  endfunction

endpackage

// File: rtl/rr_mux_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin request picker.
//   req       : per-channel request (in_valid of the selector)
//   ptr       : highest-priority channel index this cycle
//   grant     : first requesting channel at or after ptr, modulo NUM_CH
//   any_grant : high when at least one request is present
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   grant,
  output logic              any_grant
);

  logic [CH_W:0] idx;

  // Walk the offsets from farthest to nearest so the nearest requester
  // after ptr overwrites any earlier candidate. The extra index bit keeps
  // ptr+offset from overflowing before it is folded back below NUM_CH.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(NUM_CH)) begin
        idx = idx - (CH_W+1)'(NUM_CH);
      end
      if (req[idx[CH_W-1:0]]) begin
        grant = idx[CH_W-1:0];
      end
    end
  end

  assign any_grant = |req;

endmodule

// File: rtl/rr_mux.sv
// rr_mux
//   Round-robin N:1 valid/ready selector with one registered output stage.
//   CLK, RST   : clock and synchronous active-high reset
//   in_data    : NUM_CH packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready, one-hot or zero
//   out_data   : registered winning word
//   out_ch     : registered index of the channel that supplied out_data
//   out_valid  : registered output valid
//   out_ready  : downstream ready
//   Optional macro RR_MUX_FORCE_SEL_EN adds force_en/force_sel, which
//   override the arbiter without disturbing the round-robin pointer.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_valid,
`ifdef RR_MUX_FORCE_SEL_EN
  input  logic                    force_en,
  input  logic [CH_W-1:0]         force_sel,
`endif
  input  logic                    out_ready
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] arb_grant;
  logic            arb_any;
  logic [CH_W-1:0] sel;
  logic            sel_ok;
  logic            forced;
  logic            load;
  logic            xfer;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req      (in_valid),
    .ptr      (ptr_q),
    .grant    (arb_grant),
    .any_grant(arb_any)
  );

  // The output register can take a new word when it is empty or being
  // drained this very cycle, which gives back-to-back transfers.
  assign load = !out_valid || out_ready;

`ifdef RR_MUX_FORCE_SEL_EN
  // A forced select is offered ready even when that source is idle; an
  // index past the last channel selects nothing at all.
  always_comb begin
    forced = force_en;
    sel    = force_en ? force_sel : arb_grant;
    sel_ok = force_en ? (int'(force_sel) < NUM_CH) : arb_any;
  end
`else
  always_comb begin
    forced = 1'b0;
    sel    = arb_grant;
    sel_ok = arb_any;
  end
`endif

  assign in_ready = (load && sel_ok && !RST) ? (NUM_CH'(1) << sel) : '0;
  assign xfer     = load && sel_ok && in_valid[sel] && !RST;

  // Output stage: load the winner, go empty when nothing is offered, and
  // hold everything while the downstream stalls a valid word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr_q     <= '0;
    end else if (load) begin
      if (xfer) begin
        out_data  <= in_data[sel*WIDTH +: WIDTH];
        out_ch    <= sel;
        out_valid <= 1'b1;
        if (!forced) begin
          ptr_q <= CH_W'(rr_next(int'(ptr_q), int'(sel), NUM_CH));
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux
//   Directed bench for rr_mux: a 4-channel instance driven from a vector
//   table, and a 3-channel instance for the non-power-of-2 wrap. With
//   RR_MUX_FORCE_SEL_EN defined the forced-select path is exercised too.
module tb_rr_mux;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic        ordy;
    logic [3:0]  expReady;
    logic        expValid;
    logic [31:0] expData;
    logic [1:0]  expCh;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [127:0] inData4;
  logic [3:0]  inValid4;
  logic [3:0]  inReady4;
  logic [31:0] outData4;
  logic [1:0]  outCh4;
  logic        outValid4;
  logic        outReady4;

  logic        reset3;
  logic [95:0] inData3;
  logic [2:0]  inValid3;
  logic [2:0]  inReady3;
  logic [31:0] outData3;
  logic [1:0]  outCh3;
  logic        outValid3;
  logic        outReady3;

`ifdef RR_MUX_FORCE_SEL_EN
  logic        forceEn4;
  logic [1:0]  forceSel4;
  logic        forceEn3;
  logic [1:0]  forceSel3;
`endif

  int nChecks = 0;
  int nFails  = 0;
  vec_t vecs[22];

  rr_mux #(.WIDTH(32), .NUM_CH(4)) dut4 (
    .CLK      (clock),
    .RST      (reset),
    .in_data  (inData4),
    .in_valid (inValid4),
    .in_ready (inReady4),
    .out_data (outData4),
    .out_ch   (outCh4),
    .out_valid(outValid4),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en (forceEn4),
    .force_sel(forceSel4),
`endif
    .out_ready(outReady4)
  );

  rr_mux #(.WIDTH(32), .NUM_CH(3)) dut3 (
    .CLK      (clock),
    .RST      (reset3),
    .in_data  (inData3),
    .in_valid (inValid3),
    .in_ready (inReady3),
    .out_data (outData3),
    .out_ch   (outCh3),
    .out_valid(outValid3),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en (forceEn3),
    .force_sel(forceSel3),
`endif
    .out_ready(outReady3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic ordy);
    reset     = rst;
    inValid4  = valid;
    outReady4 = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) inData4[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 3; i++) inData3[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    applyStimulus(1'b1, 4'hF, 1'b1);
    reset3    = 1'b1;
    inValid3  = 3'b111;
    outReady3 = 1'b1;
`ifdef RR_MUX_FORCE_SEL_EN
    forceEn4  = 1'b0;
    forceSel4 = 2'd0;
    forceEn3  = 1'b0;
    forceSel3 = 2'd0;
`endif

    // Reset, rotation, backpressure, sparse requests, mid-transfer reset.
    vecs[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 32'h0,         2'd0};
    vecs[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 32'h0,         2'd0};
    vecs[2]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 32'hA000_0000, 2'd0};
    vecs[3]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 32'hA000_0001, 2'd1};
    vecs[4]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 32'hA000_0002, 2'd2};
    vecs[5]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 32'hA000_0003, 2'd3};
    vecs[6]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 32'hA000_0000, 2'd0};
    vecs[7]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 32'hA000_0001, 2'd1};
    for (int i = 8; i <= 12; i++)
      vecs[i] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 32'hA000_0001, 2'd1};
    vecs[13] = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 32'hA000_0002, 2'd2};
    vecs[14] = '{1'b0, 4'h8, 1'b1, 4'h8, 1'b1, 32'hA000_0003, 2'd3};
    vecs[15] = '{1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 32'hA000_0000, 2'd0};
    vecs[16] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 32'hA000_0000, 2'd0};
    vecs[17] = '{1'b0, 4'h4, 1'b0, 4'h4, 1'b1, 32'hA000_0002, 2'd2};
    vecs[18] = '{1'b0, 4'h3, 1'b1, 4'h1, 1'b1, 32'hA000_0000, 2'd0};
    vecs[19] = '{1'b0, 4'h3, 1'b1, 4'h2, 1'b1, 32'hA000_0001, 2'd1};
    vecs[20] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 32'h0,         2'd0};
    vecs[21] = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 32'hA000_0000, 2'd0};

    for (int v = 0; v < 22; v++) begin
      @(negedge clock);
      applyStimulus(vecs[v].rst, vecs[v].valid, vecs[v].ordy);
      #1;
      checkOutput($sformatf("v%0d inReady", v), 32'(inReady4), 32'(vecs[v].expReady));
      @(posedge clock);
      #1;
      checkOutput($sformatf("v%0d outValid", v), 32'(outValid4), 32'(vecs[v].expValid));
      checkOutput($sformatf("v%0d outData", v), outData4, vecs[v].expData);
      checkOutput($sformatf("v%0d outCh", v), 32'(outCh4), 32'(vecs[v].expCh));
    end

    // Three channels: the pointer must wrap from 2 back to 0.
    @(negedge clock);
    applyStimulus(1'b0, 4'h0, 1'b1);
    reset3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("n3 c%0d inReady", k), 32'(inReady3), 32'(3'b001 << (k % 3)));
      @(posedge clock);
      #1;
      checkOutput($sformatf("n3 c%0d outCh", k), 32'(outCh3), 32'(k % 3));
      checkOutput($sformatf("n3 c%0d outData", k), outData3, 32'hA000_0000 + 32'(k % 3));
      checkOutput($sformatf("n3 c%0d chRange", k), 32'(outCh3 < 2'd3), 32'd1);
      @(negedge clock);
    end

`ifdef RR_MUX_FORCE_SEL_EN
    // Forced channel 2 three times, then round-robin resumes at ch0.
    applyStimulus(1'b1, 4'hF, 1'b1);
    @(negedge clock);
    applyStimulus(1'b0, 4'hF, 1'b1);
    forceEn4  = 1'b1;
    forceSel4 = 2'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("force c%0d inReady", k), 32'(inReady4), 32'h4);
      @(posedge clock);
      #1;
      checkOutput($sformatf("force c%0d outCh", k), 32'(outCh4), 32'd2);
      checkOutput($sformatf("force c%0d outData", k), outData4, 32'hA000_0002);
      @(negedge clock);
    end
    forceEn4 = 1'b0;
    #1;
    checkOutput("unforce inReady", 32'(inReady4), 32'h1);
    @(posedge clock);
    #1;
    checkOutput("unforce outCh", 32'(outCh4), 32'd0);

    // Out-of-range forced select on the 3-channel instance grants nothing.
    @(negedge clock);
    forceEn3  = 1'b1;
    forceSel3 = 2'd3;
    #1;
    checkOutput("force3 oob inReady", 32'(inReady3), 32'h0);
    @(posedge clock);
    #1;
    checkOutput("force3 oob outValid", 32'(outValid3), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
